// File: rtl/uart_rx_fifo_if.sv
// Receive-side bus of uart_rx_fifo: serial input, FWFT byte stream and sticky error flags.
// The slave modport is the receiver's view; the master modport is the host/driver view.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  rxd;
  logic [7:0]            rdata;
  logic                  rvalid;
  logic                  rready;
  logic [DEPTH_LOG2:0]   count;
  logic                  overrun;
  logic                  frame_err;
  logic                  clear_err;

  modport slave (
    input  rxd, rready, clear_err,
    output rdata, rvalid, count, overrun, frame_err
  );

  modport master (
    output rxd, rready, clear_err,
    input  rdata, rvalid, count, overrun, frame_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with start-glitch rejection, framing/overrun detection and a
// first-word-fall-through receive FIFO drained by the host through rvalid/rready.
module uart_rx_fifo #(
  parameter int SERIAL_WCNT = 100,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(SERIAL_WCNT);

  localparam logic [CW-1:0]         CNT_HALF = CW'(SERIAL_WCNT / 2 - 1);
  localparam logic [CW-1:0]         CNT_BIT  = CW'(SERIAL_WCNT - 1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   OCC_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   OCC_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic [1:0]            r_sync;
  logic [2:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [2:0]            r_idx;
  logic [7:0]            r_shift;
  logic                  r_push;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overrun;
  logic                  r_frame_err;

  logic w_rx_s;
  logic w_samp;
  logic w_rvalid;
  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_ovr_set;
  logic w_ferr_set;

  assign w_rx_s     = r_sync[1];
  assign w_samp     = (r_cnt == '0);
  assign w_rvalid   = (r_count != '0);
  assign w_full     = (r_count == OCC_FULL);
  assign w_pop      = w_rvalid && bus.rready;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign w_wr       = r_push && (!w_full || w_pop);
  assign w_ovr_set  = r_push && w_full && !w_pop;
  assign w_ferr_set = (r_state == ST_STOP) && w_samp && !w_rx_s;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], bus.rxd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_push  <= 1'b0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_cnt   <= CNT_HALF;
          end
        end
        ST_START: begin
          if (!w_samp) r_cnt <= r_cnt - CNT_ONE;
          else if (!w_rx_s) begin
            r_state <= ST_DATA;
            r_idx   <= '0;
            r_cnt   <= CNT_BIT;
          end else r_state <= ST_IDLE;
        end
        ST_DATA: begin
          if (!w_samp) r_cnt <= r_cnt - CNT_ONE;
          else begin
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_cnt   <= CNT_BIT;
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (!w_samp) r_cnt <= r_cnt - CNT_ONE;
          else if (w_rx_s) begin
            r_push  <= 1'b1;
            r_state <= ST_IDLE;
          end else r_state <= ST_BREAK;
        end
        ST_BREAK: begin
          // Wait out a held-low line so a break yields a single framing error.
          if (w_rx_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + PTR_ONE;
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + OCC_ONE;
        2'b01:   r_count <= r_count - OCC_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovr_set)          r_overrun <= 1'b1;
      else if (bus.clear_err) r_overrun <= 1'b0;
      if (w_ferr_set)         r_frame_err <= 1'b1;
      else if (bus.clear_err) r_frame_err <= 1'b0;
    end
  end

  assign bus.rvalid    = w_rvalid;
  assign bus.rdata     = w_rvalid ? r_mem[r_rptr] : 8'h00;
  assign bus.count     = r_count;
  assign bus.overrun   = r_overrun;
  assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at 8 clocks/bit and a 4-byte FIFO: bytes expected
// to land in the FIFO are queued when sent and compared as the host pops them.
module tb_uart_rx_fifo;
  localparam int WCNT  = 8;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

  uart_rx_fifo #(.SERIAL_WCNT(WCNT), .DEPTH_LOG2(DL2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] sb[$];
  logic       exp_ovr;
  logic [7:0] head;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Line is left at the stop-bit level so a low stop bit can run into a break.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.rxd = 1'b0;
    idle(WCNT);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      idle(WCNT);
    end
    bus.rxd = stop;
    idle(WCNT);
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    chk({tag, "_vld"}, bus.rvalid, 1);
    chk({tag, "_sbq"}, sb.size() > 0, 1);
    e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    chk({tag, "_data"}, bus.rdata, e);
    bus.rready = 1'b1;
    idle(1);
    bus.rready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rxd = 1'b1; bus.rready = 1'b0; bus.clear_err = 1'b0;
    rst = 1'b1;
    idle(3);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_ovr", bus.overrun, 0);
    chk("rst_ferr", bus.frame_err, 0);
    chk("rst_rdata", bus.rdata, 0);
    rst = 1'b0;
    idle(2);

    // single byte, then drain
    sb.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    idle(4);
    chk("t1_count", bus.count, 1);
    pop_chk("t1_pop");
    chk("t1_rvalid_after", bus.rvalid, 0);
    chk("t1_count_after", bus.count, 0);

    // short low pulse is rejected as a glitch
    bus.rxd = 1'b0;
    idle(3);
    bus.rxd = 1'b1;
    idle(20);
    chk("t2_rvalid", bus.rvalid, 0);
    chk("t2_ferr", bus.frame_err, 0);
    sb.push_back(8'hA3);
    send_byte(8'hA3, 1'b1);
    idle(4);
    pop_chk("t2_pop");

    // framing error followed by a long break
    send_byte(8'h3C, 1'b0);
    idle(20 * WCNT);
    chk("t3_ferr", bus.frame_err, 1);
    chk("t3_count", bus.count, 0);
    bus.rxd = 1'b1;
    idle(6);
    sb.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    idle(4);
    chk("t3_count_81", bus.count, 1);
    chk("t3_ferr_held", bus.frame_err, 1);
    pop_chk("t3_pop");
    bus.clear_err = 1'b1;
    idle(1);
    bus.clear_err = 1'b0;
    chk("t3_ferr_clr", bus.frame_err, 0);

    // overfill: fifth byte dropped
    exp_ovr = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (sb.size() < DEPTH) sb.push_back(8'(v));
      else exp_ovr = 1'b1;
      send_byte(8'(v), 1'b1);
      idle(2);
    end
    idle(2);
    chk("t4_count", bus.count, DEPTH);
    chk("t4_ovr", bus.overrun, exp_ovr);
    chk("t4_head", bus.rdata, 8'h01);
    for (int k = 0; k < DEPTH; k++) pop_chk("t4_pop");
    chk("t4_empty", bus.count, 0);
    bus.clear_err = 1'b1;
    idle(1);
    bus.clear_err = 1'b0;
    chk("t4_ovr_clr", bus.overrun, 0);

    // full FIFO with a pop in the exact push cycle of the fifth byte
    for (int v = 1; v <= 4; v++) begin
      sb.push_back(8'(v));
      send_byte(8'(v), 1'b1);
      idle(2);
    end
    chk("t5_full", bus.count, DEPTH);
    sb.push_back(8'h05);
    fork
      send_byte(8'h05, 1'b1);
      begin
        // push cycle falls between the 79th and 80th rising edge after the start edge
        idle(79);
        head = sb.pop_front();
        chk("t5_head", bus.rdata, head);
        bus.rready = 1'b1;
        idle(1);
        bus.rready = 1'b0;
      end
    join
    idle(4);
    chk("t5_ovr", bus.overrun, 0);
    chk("t5_count", bus.count, DEPTH);
    for (int k = 0; k < DEPTH; k++) pop_chk("t5_pop");
    chk("t5_empty", bus.count, 0);

    // reset in the middle of a data bit aborts the frame
    bus.rxd = 1'b0; idle(WCNT);
    bus.rxd = 1'b0; idle(WCNT);
    bus.rxd = 1'b1; idle(4);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(10);
    chk("t6_count_rst", bus.count, 0);
    chk("t6_rvalid_rst", bus.rvalid, 0);
    sb.push_back(8'h42);
    send_byte(8'h42, 1'b1);
    idle(4);
    chk("t6_count", bus.count, 1);
    chk("t6_ovr", bus.overrun, 0);
    chk("t6_ferr", bus.frame_err, 0);
    pop_chk("t6_pop");
    chk("t6_empty", bus.count, 0);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
